// File: rtl/camera_stream_packetizer.sv
// Packs the free-running camera pixel stream into sop/eop-framed ready/valid packets.
// A show-ahead FIFO absorbs backpressure; truncated frames are closed with a filler eop word.
`timescale 1ns/1ps
module camera_stream_packetizer #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_LENGTH = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic        pixel_valid_in,
    input  logic [11:0] pixel_data_in,
    input  logic        ready_in,
    output logic        valid_out,
    output logic        startofpacket_out,
    output logic        endofpacket_out,
    output logic [11:0] data_out,
    output logic        frame_error,
    output logic [15:0] frame_count
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_LENGTH > 1) ? $clog2(IMG_LENGTH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_LENGTH - 1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [11:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        ACTIVE,
        CLOSE
    } state_t;

    state_t          state, state_n;
    logic [XW-1:0]   x, x_n;
    logic [YW-1:0]   y, y_n;
    logic            push, pop, full, empty;
    logic            err_set, cnt_inc;
    logic            at_first, at_last;
    entry_t          push_entry, head;
    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    assign full     = (count == C_FULL);
    assign empty    = (count == '0);
    assign pop      = !empty && ready_in;
    assign at_first = (x == '0) && (y == '0);
    assign at_last  = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WAIT_FRAME;
            x           <= '0;
            y           <= '0;
            frame_error <= 1'b0;
            frame_count <= '0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            if (err_set) frame_error <= 1'b1;
            if (cnt_inc) frame_count <= frame_count + 16'd1;
        end
    end

    always_comb begin
        state_n    = state;
        x_n        = x;
        y_n        = y;
        push       = 1'b0;
        push_entry = '0;
        err_set    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            WAIT_FRAME: begin
                if (vsync_in) begin
                    state_n = ACTIVE;
                    x_n     = '0;
                    y_n     = '0;
                end
            end
            ACTIVE: begin
                // A pixel arriving with vsync still belongs to the old frame.
                if (pixel_valid_in) begin
                    if (!full) begin
                        push            = 1'b1;
                        push_entry.sop  = at_first;
                        push_entry.eop  = at_last;
                        push_entry.data = pixel_data_in;
                        if (at_last) begin
                            cnt_inc = 1'b1;
                            state_n = WAIT_FRAME;
                            x_n     = '0;
                            y_n     = '0;
                        end else if (x == X_LAST) begin
                            x_n = '0;
                            y_n = y + YW'(1);
                        end else begin
                            x_n = x + XW'(1);
                        end
                    end else begin
                        err_set = 1'b1;
                        state_n = CLOSE;
                    end
                end
                if (vsync_in) begin
                    if (state_n == WAIT_FRAME) begin
                        state_n = ACTIVE;
                    end else if (state_n == ACTIVE && (x_n != '0 || y_n != '0)) begin
                        err_set = 1'b1;
                        state_n = CLOSE;
                    end
                end
            end
            CLOSE: begin
                if (!full) begin
                    push           = 1'b1;
                    push_entry.eop = 1'b1;
                    cnt_inc        = 1'b1;
                    state_n        = WAIT_FRAME;
                    x_n            = '0;
                    y_n            = '0;
                end
            end
            default: state_n = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head              = mem[rd_ptr];
    assign valid_out         = !empty;
    assign startofpacket_out = valid_out & head.sop;
    assign endofpacket_out   = valid_out & head.eop;
    assign data_out          = valid_out ? head.data : 12'h000;

endmodule

// File: tb/tb_camera_stream_packetizer.sv
// Scoreboard bench: stimulus queues expected {sop,eop,data} words, monitors pop and compare.
`timescale 1ns/1ps
module tb_camera_stream_packetizer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        vsync = 0, pv = 0, rdy = 0;
    logic [11:0] pd = '0;
    logic        valid, sop, eop, ferr;
    logic [11:0] dout;
    logic [15:0] fcnt;

    logic        vsync_d = 0, pv_d = 0, rdy_d = 0;
    logic [11:0] pd_d = '0;
    logic        valid_d, sop_d, eop_d, ferr_d;
    logic [11:0] dout_d;
    logic [15:0] fcnt_d;

    camera_stream_packetizer #(.IMG_WIDTH(4), .IMG_LENGTH(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .vsync_in(vsync), .pixel_valid_in(pv),
        .pixel_data_in(pd), .ready_in(rdy), .valid_out(valid),
        .startofpacket_out(sop), .endofpacket_out(eop), .data_out(dout),
        .frame_error(ferr), .frame_count(fcnt));

    camera_stream_packetizer dut_d (
        .clk(clk), .reset(reset), .vsync_in(vsync_d), .pixel_valid_in(pv_d),
        .pixel_data_in(pd_d), .ready_in(rdy_d), .valid_out(valid_d),
        .startofpacket_out(sop_d), .endofpacket_out(eop_d), .data_out(dout_d),
        .frame_error(ferr_d), .frame_count(fcnt_d));

    int n_vec = 0;
    int n_err = 0;
    logic [13:0] exp_q[$];
    logic [13:0] exp_d[$];
    localparam logic [13:0] FILLER = 14'b01_0000_0000_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic vs, input logic p, input logic [11:0] d);
        @(posedge clk); #1;
        vsync = vs; pv = p; pd = d;
    endtask

    task automatic drive_d(input logic vs, input logic p, input logic [11:0] d);
        @(posedge clk); #1;
        vsync_d = vs; pv_d = p; pd_d = d;
    endtask

    task automatic push_clean();
        for (int i = 0; i < 12; i++) exp_q.push_back({(i == 0), (i == 11), 12'(i)});
    endtask

    task automatic frame(input int n);
        drive(1, 0, 0);
        for (int i = 0; i < n; i++) drive(0, 1, 12'(i));
        drive(0, 0, 0);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(name, exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor for the small instance: pops on every accepted word, checks stall stability.
    logic [13:0] held;
    bit          held_v = 0;
    always @(negedge clk) begin
        if (reset) begin
            held_v = 0;
        end else if (valid) begin
            if (held_v) chk("stable", {sop, eop, dout}, held);
            if (rdy) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", {sop, eop, dout}, $time);
                end else begin
                    chk("word", {sop, eop, dout}, exp_q.pop_front());
                end
                held_v = 0;
            end else begin
                held   = {sop, eop, dout};
                held_v = 1;
            end
        end else begin
            held_v = 0;
        end
    end

    always @(negedge clk) begin
        if (!reset && valid_d && rdy_d) begin
            if (exp_d.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word_d: got %0h expected none", {sop_d, eop_d, dout_d});
            end else begin
                chk("word_d", {sop_d, eop_d, dout_d}, exp_d.pop_front());
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_sop", sop, 0);
        chk("rst_eop", eop, 0);
        chk("rst_data", dout, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_fcnt", fcnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: back-to-back frame, one-cycle latency
        rdy = 1;
        push_clean();
        drive(1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 12'(i));
            if (i > 0) begin
                @(negedge clk);
                chk("t1_latency", {valid, dout}, {1'b1, 12'(i - 1)});
            end
        end
        drive(0, 0, 0);
        @(negedge clk);
        chk("t1_last", {valid, eop, dout}, {1'b1, 1'b1, 12'd11});
        wait_drain("t1_drain");
        chk("t1_fcnt", fcnt, 1);
        chk("t1_ferr", ferr, 0);

        // 2: ready toggling every cycle, pixels every other cycle
        push_clean();
        drive(1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 12'(i));
            rdy = 0;
            drive(0, 0, 0);
            rdy = 1;
        end
        wait_drain("t2_drain");
        chk("t2_fcnt", fcnt, 2);
        chk("t2_ferr", ferr, 0);

        // 3: overflow with ready held low
        rdy = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), 1'b0, 12'(i)});
        exp_q.push_back(FILLER);
        frame(5);
        repeat (3) @(negedge clk);
        chk("t3_ferr", ferr, 1);
        chk("t3_head", {valid, sop, dout}, {1'b1, 1'b1, 12'd0});
        rdy = 1;
        wait_drain("t3_drain");
        for (int i = 5; i < 12; i++) drive(0, 1, 12'(i));
        drive(0, 0, 0);
        repeat (5) @(negedge clk);
        chk("t3_fcnt", fcnt, 3);

        // 4: short frame closed by vsync, next frame skipped, third clean
        do_reset();
        rdy = 1;
        for (int i = 0; i < 6; i++) exp_q.push_back({(i == 0), 1'b0, 12'(i)});
        exp_q.push_back(FILLER);
        push_clean();
        frame(6);
        frame(12);
        repeat (3) drive(0, 0, 0);
        frame(12);
        wait_drain("t4_drain");
        chk("t4_fcnt", fcnt, 2);
        chk("t4_ferr", ferr, 1);

        // 6: async reset mid-frame
        do_reset();
        rdy = 0;
        frame(7);
        @(negedge clk);
        chk("t6_pre_ferr", ferr, 1);
        chk("t6_pre_valid", valid, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_valid", valid, 0);
        chk("t6_data", dout, 0);
        chk("t6_fcnt", fcnt, 0);
        chk("t6_ferr", ferr, 0);
        @(negedge clk);
        reset = 1'b0;
        rdy = 1;
        push_clean();
        frame(12);
        wait_drain("t6_drain");
        chk("t6_post_fcnt", fcnt, 1);

        // 5: full-size 320x240 gradient frame
        rdy_d = 1;
        for (int i = 0; i < 76800; i++) exp_d.push_back({(i == 0), (i == 76799), 12'(i)});
        drive_d(1, 0, 0);
        for (int i = 0; i < 76800; i++) drive_d(0, 1, 12'(i));
        drive_d(0, 0, 0);
        begin
            int t = 0;
            while (exp_d.size() != 0 && t < 300) begin
                @(negedge clk);
                t++;
            end
        end
        chk("t5_drain", exp_d.size(), 0);
        chk("t5_fcnt", fcnt_d, 1);
        chk("t5_ferr", ferr_d, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
